multi_chan_fifo: RTL and testbench

// Single-clock FIFO with NUM_CHAN independent logical channels on shared storage. Each channel is
// an in-order queue of 2**LOG_DEPTH words with its own flush. A round-robin arbiter merges the
// non-empty channels onto one valid/ready output. Used ahead of CDC or interconnect ports that

---
 rtl/multi_chan_fifo.sv | 198 +++++++++++++++++++
 tb/tb_multi_chan_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_chan_fifo.sv
// multi_chan_fifo: NUM_CHAN logical FIFOs on shared storage, merged round-robin onto one valid/ready port.
// Define MULTI_CHAN_FIFO_SPILL_EN to register the merged output through a two-entry spill register.
module multi_chan_fifo #(
   parameter int  WIDTH     = 8,
   parameter type T         = logic [WIDTH-1:0],
   parameter int  NUM_CHAN  = 4,
   parameter int  LOG_DEPTH = 2,
   localparam int ChanW     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  T                                  src_data_i,
   input  logic [ChanW-1:0]                  src_chan_i,
   input  logic                              src_valid_i,
   output logic                              src_ready_o,
   input  logic [NUM_CHAN-1:0]               clear_i,
   output T                                  dst_data_o,
   output logic [ChanW-1:0]                  dst_chan_o,
   output logic                              dst_valid_o,
   input  logic                              dst_ready_i,
   output logic [NUM_CHAN*(LOG_DEPTH+1)-1:0] fill_o,
   output logic                              err_o
);
   localparam int PtrW  = LOG_DEPTH + 1;
   localparam int Depth = 2 ** LOG_DEPTH;

   logic [PtrW-1:0]     wptr_q [NUM_CHAN];
   logic [PtrW-1:0]     wptr_d [NUM_CHAN];
   logic [PtrW-1:0]     rptr_q [NUM_CHAN];
   logic [PtrW-1:0]     rptr_d [NUM_CHAN];
   logic [ChanW-1:0]    rr_q, rr_d, gnt_q, gnt_d;
   logic                lock_q, lock_d, err_q, err_d;
   T                    mem_q [NUM_CHAN][Depth];

   logic [NUM_CHAN-1:0] empty_s, full_s;
   logic [ChanW-1:0]    grant_s;
   logic                in_range_s, ready_s, wr_en_s, found_s;
   logic                arb_valid_s, arb_ready_s, rd_en_s;
   int                  idx_s;
   T                    arb_data_s;

   // Per-channel empty/full/occupancy from the registered pointers.
   always_comb begin
      for (int c = 0; c < NUM_CHAN; c++) begin
         empty_s[c]             = (wptr_q[c] == rptr_q[c]);
         full_s[c]              = ((wptr_q[c] ^ rptr_q[c]) == {1'b1, {LOG_DEPTH{1'b0}}});
         fill_o[c*PtrW +: PtrW] = wptr_q[c] - rptr_q[c];
      end
   end

   // Write acceptance; out-of-range channels are always ready and their words dropped.
   always_comb begin
      in_range_s = (int'(src_chan_i) < NUM_CHAN);
      ready_s    = 1'b1;
      for (int c = 0; c < NUM_CHAN; c++) begin
         ready_s = ready_s & ~((int'(src_chan_i) == c) & full_s[c]);
      end
      src_ready_o = ready_s;
      wr_en_s     = src_valid_i & ready_s & in_range_s;
      err_d       = src_valid_i & ~in_range_s;
   end

   // Round-robin grant search from rr_q; a stalled output keeps its grant frozen.
   always_comb begin
      grant_s = gnt_q;
      found_s = 1'b0;
      idx_s   = 0;
      if (!lock_q) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            idx_s = (int'(rr_q) + i) % NUM_CHAN;
            if (!found_s && !empty_s[idx_s]) begin
               found_s = 1'b1;
               grant_s = ChanW'(idx_s);
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         grant_s = gnt_q;
      end
      arb_valid_s = |(~empty_s);
      arb_data_s  = mem_q[grant_s][rptr_q[grant_s][LOG_DEPTH-1:0]];
      rd_en_s     = arb_valid_s & arb_ready_s;
      lock_d      = arb_valid_s & ~arb_ready_s & ~clear_i[grant_s];
      gnt_d       = grant_s;
      if (rd_en_s) begin
         rr_d = (int'(grant_s) == NUM_CHAN - 1) ? '0 : grant_s + 1'b1;
      end else begin
         rr_d = rr_q;
      end
   end

   // Pointer next state; a flush overrides any read or write on that channel.
   always_comb begin
      for (int c = 0; c < NUM_CHAN; c++) begin
         wptr_d[c] = wptr_q[c];
         rptr_d[c] = rptr_q[c];
         if (clear_i[c]) begin
            wptr_d[c] = '0;
            rptr_d[c] = '0;
         end else begin
            if (wr_en_s && (int'(src_chan_i) == c)) begin
               wptr_d[c] = wptr_q[c] + 1'b1;
            end else begin
               wptr_d[c] = wptr_q[c];
            end
            if (rd_en_s && (int'(grant_s) == c)) begin
               rptr_d[c] = rptr_q[c] + 1'b1;
            end else begin
               rptr_d[c] = rptr_q[c];
            end
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
         end
         rr_q   <= '0;
         gnt_q  <= '0;
         lock_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         rr_q   <= rr_d;
         gnt_q  <= gnt_d;
         lock_q <= lock_d;
         err_q  <= err_d;
      end
   end

   // Shared payload storage, intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         mem_q[src_chan_i][wptr_q[src_chan_i][LOG_DEPTH-1:0]] <= src_data_i;
      end
   end

   assign err_o = err_q;

`ifdef MULTI_CHAN_FIFO_SPILL_EN
   logic             a_full_q, a_full_d, b_full_q, b_full_d;
   logic             a_fill_s, a_drain_s, b_fill_s, b_drain_s;
   logic [ChanW-1:0] a_chan_q, a_chan_d, b_chan_q, b_chan_d;
   T                 a_data_q, a_data_d, b_data_q, b_data_d;

   // Spill register: slot b only holds a word when the consumer stalls, so it is always the older one.
   always_comb begin
      arb_ready_s = ~a_full_q | ~b_full_q;
      a_fill_s    = arb_valid_s & arb_ready_s;
      a_drain_s   = a_full_q & ~b_full_q;
      b_fill_s    = a_drain_s & ~dst_ready_i;
      b_drain_s   = b_full_q & dst_ready_i;
      a_full_d    = a_fill_s | (a_full_q & ~a_drain_s);
      b_full_d    = b_fill_s | (b_full_q & ~b_drain_s);
      a_chan_d    = a_fill_s ? grant_s : a_chan_q;
      a_data_d    = a_fill_s ? arb_data_s : a_data_q;
      b_chan_d    = b_fill_s ? a_chan_q : b_chan_q;
      b_data_d    = b_fill_s ? a_data_q : b_data_q;
      dst_valid_o = a_full_q | b_full_q;
      dst_chan_o  = b_full_q ? b_chan_q : a_chan_q;
      dst_data_o  = b_full_q ? b_data_q : a_data_q;
   end

   // Spill register state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_chan_q <= '0;
         b_chan_q <= '0;
         a_data_q <= '0;
         b_data_q <= '0;
      end else begin
         a_full_q <= a_full_d;
         b_full_q <= b_full_d;
         a_chan_q <= a_chan_d;
         b_chan_q <= b_chan_d;
         a_data_q <= a_data_d;
         b_data_q <= b_data_d;
      end
   end
`else
   // Output straight from storage: a word is visible the cycle after it is written.
   always_comb begin
      arb_ready_s = dst_ready_i;
      dst_valid_o = arb_valid_s;
      dst_chan_o  = grant_s;
      dst_data_o  = arb_data_s;
   end
`endif

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Randomized and directed bench for multi_chan_fifo (default build) against a queue-based reference model.
module tb_multi_chan_fifo;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  src_data, dst_data;
   logic [1:0]  src_chan, dst_chan;
   logic        src_valid, src_ready, dst_valid, dst_ready, err;
   logic [3:0]  clear;
   logic [11:0] fill;

   logic [7:0]  s5_data, s5_dst_data;
   logic [2:0]  s5_chan, s5_dst_chan;
   logic        s5_valid, s5_ready, s5_dst_valid, s5_err;
   logic [14:0] s5_fill;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  m_q [4][$];
   int          m_rr, m_lock_chan;
   logic        m_lock;

   logic        obs_ready, obs_valid, obs_err;
   logic [1:0]  obs_chan;
   logic [7:0]  obs_data;
   logic [11:0] obs_fill;

   always #5 clk = ~clk;

   multi_chan_fifo u_dut (
      .clk_i(clk), .rst_i(rst), .src_data_i(src_data), .src_chan_i(src_chan),
      .src_valid_i(src_valid), .src_ready_o(src_ready), .clear_i(clear),
      .dst_data_o(dst_data), .dst_chan_o(dst_chan), .dst_valid_o(dst_valid),
      .dst_ready_i(dst_ready), .fill_o(fill), .err_o(err)
   );

   multi_chan_fifo #(.NUM_CHAN(5)) u_dut5 (
      .clk_i(clk), .rst_i(rst), .src_data_i(s5_data), .src_chan_i(s5_chan),
      .src_valid_i(s5_valid), .src_ready_o(s5_ready), .clear_i(5'b00000),
      .dst_data_o(s5_dst_data), .dst_chan_o(s5_dst_chan), .dst_valid_o(s5_dst_valid),
      .dst_ready_i(1'b0), .fill_o(s5_fill), .err_o(s5_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle on the main DUT: apply inputs, compare with the model, then advance the model.
   task automatic cyc(input logic v, input logic [1:0] ch, input logic [7:0] d,
                      input logic [3:0] clr, input logic rdy);
      logic er, ev, hs, wr, found;
      int   g, idx;
      src_valid = v; src_chan = ch; src_data = d; clear = clr; dst_ready = rdy;
      @(negedge clk);
      er = (m_q[ch].size() < 4);
      ev = 1'b0;
      for (int i = 0; i < 4; i++) if (m_q[i].size() != 0) ev = 1'b1;
      g = 0;
      found = 1'b0;
      if (m_lock) g = m_lock_chan;
      else begin
         for (int i = 0; i < 4; i++) begin
            idx = (m_rr + i) % 4;
            if (!found && m_q[idx].size() != 0) begin
               found = 1'b1;
               g = idx;
            end
         end
      end
      obs_ready = src_ready; obs_valid = dst_valid; obs_chan = dst_chan;
      obs_data = dst_data; obs_fill = fill; obs_err = err;
      check_eq("src_ready", {31'd0, src_ready}, {31'd0, er});
      check_eq("dst_valid", {31'd0, dst_valid}, {31'd0, ev});
      if (ev) begin
         check_eq("dst_chan", {30'd0, dst_chan}, g);
         check_eq("dst_data", {24'd0, dst_data}, {24'd0, m_q[g][0]});
      end
      for (int c = 0; c < 4; c++) check_eq("fill", {29'd0, fill[c*3 +: 3]}, m_q[c].size());
      check_eq("err", {31'd0, err}, 32'd0);
      @(posedge clk);
      hs = ev & rdy;
      wr = v & er;
      for (int c = 0; c < 4; c++) begin
         if (clr[c]) m_q[c].delete();
         else begin
            if (hs && g == c) void'(m_q[c].pop_front());
            if (wr && int'(ch) == c) m_q[c].push_back(d);
         end
      end
      if (hs) m_rr = (g + 1) % 4;
      m_lock = ev & ~rdy & ~clr[g];
      m_lock_chan = g;
      #1;
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, 2'd0, 8'h00, 4'b0000, rdy);
   endtask

   task automatic do_reset();
      src_valid = 1'b0; src_chan = 2'd0; src_data = 8'h00; clear = 4'b0000; dst_ready = 1'b0;
      s5_valid = 1'b0; s5_chan = 3'd0; s5_data = 8'h00;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_valid", {31'd0, dst_valid}, 32'd0);
      check_eq("rst_fill", {20'd0, fill}, 32'd0);
      check_eq("rst_err", {31'd0, err}, 32'd0);
      check_eq("rst_ready", {31'd0, src_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) m_q[c].delete();
      m_rr = 0; m_lock = 1'b0; m_lock_chan = 0;
   endtask

   task automatic cyc5(input logic v, input logic [2:0] ch, input logic [7:0] d);
      s5_valid = v; s5_chan = ch; s5_data = d;
      @(negedge clk);
   endtask

   initial begin
      int seq [6];
      int pct;
      logic [3:0] clr;
      seq = '{0, 1, 3, 0, 1, 3};

      do_reset();
      // Out-of-range write on a 5-channel instance.
      cyc5(1'b1, 3'd5, 8'h3C);
      check_eq("oor_ready", {31'd0, s5_ready}, 32'd1);
      check_eq("oor_err_now", {31'd0, s5_err}, 32'd0);
      @(posedge clk); #1;
      cyc5(1'b0, 3'd0, 8'h00);
      check_eq("oor_err_pulse", {31'd0, s5_err}, 32'd1);
      check_eq("oor_fill", {17'd0, s5_fill}, 32'd0);
      check_eq("oor_valid", {31'd0, s5_dst_valid}, 32'd0);
      @(posedge clk); #1;
      cyc5(1'b1, 3'd4, 8'h77);
      check_eq("oor_err_clr", {31'd0, s5_err}, 32'd0);
      @(posedge clk); #1;
      cyc5(1'b0, 3'd0, 8'h00);
      check_eq("ch4_err", {31'd0, s5_err}, 32'd0);
      check_eq("ch4_fill", {29'd0, s5_fill[14:12]}, 32'd1);
      check_eq("ch4_chan", {29'd0, s5_dst_chan}, 32'd4);
      check_eq("ch4_data", {24'd0, s5_dst_data}, 32'h77);
      @(posedge clk); #1;

      // Single word latency.
      do_reset();
      cyc(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0);
      check_eq("lat_valid0", {31'd0, obs_valid}, 32'd0);
      idle(1'b0);
      check_eq("lat_valid1", {31'd0, obs_valid}, 32'd1);
      check_eq("lat_chan", {30'd0, obs_chan}, 32'd2);
      check_eq("lat_data", {24'd0, obs_data}, 32'hA5);
      check_eq("lat_fill1", {29'd0, obs_fill[8:6]}, 32'd1);
      idle(1'b1);
      idle(1'b0);
      check_eq("lat_fill0", {29'd0, obs_fill[8:6]}, 32'd0);

      // Fill channel 1 to capacity.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'd1, 8'h10 + 8'(i), 4'b0000, 1'b0);
      cyc(1'b1, 2'd1, 8'h99, 4'b0000, 1'b0);
      check_eq("full_ready1", {31'd0, obs_ready}, 32'd0);
      idle(1'b0);
      check_eq("full_ready0", {31'd0, obs_ready}, 32'd1);
      check_eq("full_fill", {29'd0, obs_fill[5:3]}, 32'd4);
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         check_eq("full_drain", {24'd0, obs_data}, 32'h10 + i);
      end

      // Round-robin order.
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1'b1, 2'(seq[i % 3]), 8'h40 + 8'(i), 4'b0000, 1'b0);
      for (int i = 0; i < 6; i++) begin
         idle(1'b1);
         check_eq("rr_order", {30'd0, obs_chan}, seq[i]);
      end

      // Grant stays locked while the consumer stalls.
      do_reset();
      cyc(1'b1, 2'd2, 8'hC2, 4'b0000, 1'b0);
      cyc(1'b1, 2'd0, 8'hC0, 4'b0000, 1'b0);
      idle(1'b0);
      check_eq("lock_hold", {30'd0, obs_chan}, 32'd2);
      idle(1'b1);
      check_eq("lock_hs", {30'd0, obs_chan}, 32'd2);
      idle(1'b0);
      check_eq("lock_next", {30'd0, obs_chan}, 32'd0);
      check_eq("lock_next_data", {24'd0, obs_data}, 32'hC0);

      // Flush overrides a simultaneous write.
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1, 8'h50 + 8'(i), 4'b0000, 1'b0);
      cyc(1'b1, 2'd1, 8'hEE, 4'b0010, 1'b0);
      idle(1'b0);
      check_eq("clr_fill", {29'd0, obs_fill[5:3]}, 32'd0);
      check_eq("clr_valid", {31'd0, obs_valid}, 32'd0);

      // Randomized traffic with phases of heavy and light back-pressure.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         pct = ((n / 400) % 2 == 1) ? 2 : 8;
         clr = 4'b0000;
         if ($urandom_range(0, 39) == 0) clr[$urandom_range(0, 3)] = 1'b1;
         cyc($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 8'($urandom), clr,
             $urandom_range(0, 9) < pct);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
